// File: rtl/ahb_matrix_pkg.sv
// Shared encodings and types for the AHB bus-matrix decoder slice.
package ahb_matrix_pkg;

    localparam int unsigned ADDR_LSB = 10;
    localparam int unsigned DEC_W    = 22;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DftIdle = 2'b00,
        DftErr1 = 2'b01,
        DftErr2 = 2'b10
    } dft_state_e;

endpackage

// File: rtl/ahb_matrix_default_slave_fsm.sv
// Default slave: answers unmapped NONSEQ/SEQ with a two-cycle ERROR response,
// IDLE/BUSY with a zero-wait OKAY.
module ahb_matrix_default_slave_fsm
    import ahb_matrix_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       dft_sel,
    input  logic       HREADYS,
    input  logic       trans_act,
    output logic       hreadyout,
    output logic [1:0] hresp
);

    dft_state_e state_q, state_d;
    logic       accept;

    assign accept = dft_sel & HREADYS & trans_act;

    // State register; reset abandons any response in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= DftIdle;
        else        state_q <= state_d;
    end

    // Next state and response outputs.
    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        unique case (state_q)
            DftIdle: begin
                if (accept) state_d = DftErr1;
            end
            DftErr1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = DftErr2;
            end
            DftErr2: begin
                hresp   = HRESP_ERROR;
                state_d = accept ? DftErr1 : DftIdle;
            end
            default: state_d = DftIdle;
        endcase
    end

endmodule

// File: rtl/ahb_matrix_decoder_param.sv
// Parametrised slave-side decoder: region decode to NUM_PORTS output stages,
// data-phase response mux, default ERROR slave and unmapped-access capture.
module ahb_matrix_decoder_param
    import ahb_matrix_pkg::*;
#(
    parameter int unsigned                NUM_PORTS    = 2,
    parameter logic [NUM_PORTS*DEC_W-1:0] REGION_BASE  = {22'h140130, 22'h140000},
    parameter logic [NUM_PORTS*DEC_W-1:0] REGION_LIMIT = {22'h14013f, 22'h14012c},
    parameter int unsigned                CNT_W        = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HREADYS,
    input  logic                    sel_dec,
    input  logic [DEC_W-1:0]        decode_addr_dec,
    input  logic [1:0]              trans_dec,
    input  logic [NUM_PORTS-1:0]    active_vec,
    input  logic [NUM_PORTS-1:0]    readyout_vec,
    input  logic [2*NUM_PORTS-1:0]  resp_vec,
    input  logic [32*NUM_PORTS-1:0] rdata_vec,
    output logic [NUM_PORTS-1:0]    sel_vec,
    output logic                    active_dec,
    output logic                    HREADYOUTS,
    output logic [1:0]              HRESPS,
    output logic [31:0]             HRDATAS,
    input  logic                    err_clr,
    output logic                    err_valid,
    output logic [DEC_W-1:0]        err_addr,
    output logic [CNT_W-1:0]        err_count
);

    localparam int unsigned      IDX_W   = $clog2(NUM_PORTS + 1);
    localparam logic [IDX_W-1:0] DEF     = IDX_W'(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]     addr_port, data_port_q;
    logic [NUM_PORTS-1:0] region_hit;
    logic                 dft_sel, dft_ready, err_event;
    logic [1:0]           dft_resp;
    logic                 err_valid_q;
    logic [DEC_W-1:0]     err_addr_q;
    logic [CNT_W-1:0]     err_count_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign region_hit[i] = (decode_addr_dec >= REGION_BASE[DEC_W*i +: DEC_W]) &&
                               (decode_addr_dec <= REGION_LIMIT[DEC_W*i +: DEC_W]);
        assign sel_vec[i]    = sel_dec & (addr_port == IDX_W'(i));
    end

    // Address decode: lowest matching region wins, else IDLE holds the last port.
    always_comb begin
        addr_port = DEF;
        if (data_port_q != DEF && trans_dec == HTRANS_IDLE) addr_port = data_port_q;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (region_hit[i]) addr_port = IDX_W'(i);
        end
    end

    assign dft_sel   = sel_dec & (addr_port == DEF);
    assign err_event = dft_sel & HREADYS & trans_dec[1];

    // Address-phase active mux; the default slave is always active.
    always_comb begin
        active_dec = 1'b1;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (addr_port == IDX_W'(i)) active_dec = active_vec[i];
        end
    end

    // Data-phase port register, advanced only on completed transfers.
    always_ff @(posedge HCLK) begin
        if (HRESET)       data_port_q <= DEF;
        else if (HREADYS) data_port_q <= addr_port;
    end

    // Data-phase response mux.
    always_comb begin
        HREADYOUTS = dft_ready;
        HRESPS     = dft_resp;
        HRDATAS    = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (data_port_q == IDX_W'(i)) begin
                HREADYOUTS = readyout_vec[i];
                HRESPS     = resp_vec[2*i +: 2];
                HRDATAS    = rdata_vec[32*i +: 32];
            end
        end
    end

    ahb_matrix_default_slave_fsm u_dft_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .dft_sel   (dft_sel),
        .HREADYS   (HREADYS),
        .trans_act (trans_dec[1]),
        .hreadyout (dft_ready),
        .hresp     (dft_resp)
    );

    // Unmapped-access capture; a simultaneous event beats err_clr.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else if (err_event) begin
            if (!err_valid_q || err_clr) err_addr_q <= decode_addr_dec;
            err_valid_q <= 1'b1;
            if (err_clr)                   err_count_q <= CNT_W'(1);
            else if (err_count_q != CNT_MAX) err_count_q <= err_count_q + CNT_W'(1);
        end else if (err_clr) begin
            err_valid_q <= 1'b0;
            err_count_q <= '0;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ahb_matrix_decoder_param.sv
// Bench for ahb_matrix_decoder_param: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_ahb_matrix_decoder_param;

    localparam int DEF = 2;

    logic        HCLK, HRESET, HREADYS, sel_dec, err_clr;
    logic [21:0] decode_addr_dec;
    logic [1:0]  trans_dec, active_vec, readyout_vec;
    logic [3:0]  resp_vec;
    logic [63:0] rdata_vec;

    logic [1:0]  sel_vec, HRESPS, sel_vec2, HRESPS2;
    logic        active_dec, HREADYOUTS, err_valid, active_dec2, HREADYOUTS2, err_valid2;
    logic [31:0] HRDATAS, HRDATAS2;
    logic [21:0] err_addr, err_addr2;
    logic [7:0]  err_count;
    logic [1:0]  err_count2;

    int n_checks = 0;
    int n_pass   = 0;

    ahb_matrix_decoder_param dut (
        .HCLK(HCLK), .HRESET(HRESET), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_vec(active_vec),
        .readyout_vec(readyout_vec), .resp_vec(resp_vec), .rdata_vec(rdata_vec),
        .sel_vec(sel_vec), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .HRDATAS(HRDATAS), .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
        .err_count(err_count)
    );

    ahb_matrix_decoder_param #(.CNT_W(2)) dut_c2 (
        .HCLK(HCLK), .HRESET(HRESET), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_vec(active_vec),
        .readyout_vec(readyout_vec), .resp_vec(resp_vec), .rdata_vec(rdata_vec),
        .sel_vec(sel_vec2), .active_dec(active_dec2), .HREADYOUTS(HREADYOUTS2),
        .HRESPS(HRESPS2), .HRDATAS(HRDATAS2), .err_clr(err_clr), .err_valid(err_valid2),
        .err_addr(err_addr2), .err_count(err_count2)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic next_cycle;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle;
        sel_dec = 1'b0; trans_dec = 2'b00; decode_addr_dec = 22'h0;
        HREADYS = 1'b1; err_clr = 1'b0;
    endtask

    task automatic drive_xfer(input logic [21:0] a, input logic [1:0] t, input logic rdy);
        sel_dec = 1'b1; trans_dec = t; decode_addr_dec = a; HREADYS = rdy; err_clr = 1'b0;
    endtask

    task automatic do_reset;
        drive_idle();
        active_vec = 2'b10; readyout_vec = 2'b11; resp_vec = 4'b0000;
        rdata_vec = {32'hA5A5_0002, 32'hA5A5_0001};
        HRESET = 1'b1;
        next_cycle();
        next_cycle();
        HRESET = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (sel_vec !== 2'b00) $display("FAIL reset_sel: got %b want 00", sel_vec); else n_pass++;
        n_checks++; if (HREADYOUTS !== 1'b1) $display("FAIL reset_ready: got %b want 1", HREADYOUTS); else n_pass++;
        n_checks++; if (HRESPS !== 2'b00) $display("FAIL reset_resp: got %b want 00", HRESPS); else n_pass++;
        n_checks++; if (HRDATAS !== 32'h0) $display("FAIL reset_rdata(data_port=DEF): got %h want 0", HRDATAS); else n_pass++;
        n_checks++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid: got %b want 0", err_valid); else n_pass++;
        n_checks++; if (err_addr !== 22'h0) $display("FAIL reset_err_addr: got %h want 0", err_addr); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_mapped;
        do_reset();
        drive_xfer(22'h140000, 2'b10, 1'b1);
        #1;
        n_checks++; if (sel_vec !== 2'b01) $display("FAIL map_sel0: got %b want 01", sel_vec); else n_pass++;
        n_checks++; if (active_dec !== 1'b0) $display("FAIL map_active0: got %b want 0", active_dec); else n_pass++;
        next_cycle();
        drive_xfer(22'h140135, 2'b10, 1'b1);
        #1;
        n_checks++; if (sel_vec !== 2'b10) $display("FAIL map_sel1: got %b want 10", sel_vec); else n_pass++;
        n_checks++; if (active_dec !== 1'b1) $display("FAIL map_active1: got %b want 1", active_dec); else n_pass++;
        n_checks++; if (HRDATAS !== 32'hA5A5_0001) $display("FAIL map_rdata0: got %h want a5a50001", HRDATAS); else n_pass++;
        next_cycle();
        drive_idle();
        #1;
        n_checks++; if (HRDATAS !== 32'hA5A5_0002) $display("FAIL map_rdata1: got %h want a5a50002", HRDATAS); else n_pass++;
        n_checks++; if (sel_vec !== 2'b00) $display("FAIL map_nosel: got %b want 00", sel_vec); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL map_err_count: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_boundaries;
        logic [21:0] addrs [8] = '{22'h13ffff, 22'h140000, 22'h14012c, 22'h14012d,
                                   22'h14012f, 22'h140130, 22'h14013f, 22'h140140};
        logic [1:0]  sels  [8] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive_xfer(addrs[k], 2'b10, 1'b0);
            #1;
            n_checks++;
            if (sel_vec !== sels[k])
                $display("FAIL boundary_sel[%h]: got %b want %b", addrs[k], sel_vec, sels[k]);
            else n_pass++;
        end
        drive_idle();
    endtask

    task automatic test_unmapped;
        do_reset();
        drive_xfer(22'h200000, 2'b10, 1'b1);
        #1;
        n_checks++; if (sel_vec !== 2'b00) $display("FAIL unm_sel: got %b want 00", sel_vec); else n_pass++;
        n_checks++; if (active_dec !== 1'b1) $display("FAIL unm_active: got %b want 1", active_dec); else n_pass++;
        next_cycle();
        drive_idle(); HREADYS = 1'b0;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b0) $display("FAIL unm_err1_ready: got %b want 0", HREADYOUTS); else n_pass++;
        n_checks++; if (HRESPS !== 2'b01) $display("FAIL unm_err1_resp: got %b want 01", HRESPS); else n_pass++;
        n_checks++; if (err_valid !== 1'b1) $display("FAIL unm_err_valid: got %b want 1", err_valid); else n_pass++;
        n_checks++; if (err_addr !== 22'h200000) $display("FAIL unm_err_addr: got %h want 200000", err_addr); else n_pass++;
        n_checks++; if (err_count !== 8'd1) $display("FAIL unm_err_count: got %0d want 1", err_count); else n_pass++;
        next_cycle();
        drive_idle();
        #1;
        n_checks++; if (HREADYOUTS !== 1'b1) $display("FAIL unm_err2_ready: got %b want 1", HREADYOUTS); else n_pass++;
        n_checks++; if (HRESPS !== 2'b01) $display("FAIL unm_err2_resp: got %b want 01", HRESPS); else n_pass++;
        next_cycle();
        n_checks++; if (HRESPS !== 2'b00) $display("FAIL unm_after_resp: got %b want 00", HRESPS); else n_pass++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        drive_xfer(22'h200000, 2'b10, 1'b1);
        next_cycle();
        drive_xfer(22'h300000, 2'b10, 1'b0);
        #1;
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b001) $display("FAIL b2b_err1a: got %b want 001", {HREADYOUTS, HRESPS}); else n_pass++;
        next_cycle();
        HREADYS = 1'b1;
        #1;
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b101) $display("FAIL b2b_err2a: got %b want 101", {HREADYOUTS, HRESPS}); else n_pass++;
        next_cycle();
        drive_idle(); HREADYS = 1'b0;
        #1;
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b001) $display("FAIL b2b_err1b: got %b want 001", {HREADYOUTS, HRESPS}); else n_pass++;
        n_checks++; if (err_addr !== 22'h200000) $display("FAIL b2b_err_addr: got %h want 200000", err_addr); else n_pass++;
        n_checks++; if (err_count !== 8'd2) $display("FAIL b2b_err_count: got %0d want 2", err_count); else n_pass++;
        next_cycle();
        HREADYS = 1'b1;
        #1;
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b101) $display("FAIL b2b_err2b: got %b want 101", {HREADYOUTS, HRESPS}); else n_pass++;
        next_cycle();
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b100) $display("FAIL b2b_idle: got %b want 100", {HREADYOUTS, HRESPS}); else n_pass++;
    endtask

    task automatic test_saturate;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_xfer(22'h200000 + 22'(k), 2'b10, 1'b1);
            next_cycle();
            drive_idle(); HREADYS = 1'b0;
            next_cycle();
            HREADYS = 1'b1;
            next_cycle();
        end
        n_checks++; if (err_count2 !== 2'd3) $display("FAIL sat_count_w2: got %0d want 3", err_count2); else n_pass++;
        n_checks++; if (err_count !== 8'd5) $display("FAIL sat_count_w8: got %0d want 5", err_count); else n_pass++;
        n_checks++; if (err_addr2 !== 22'h200000) $display("FAIL sat_err_addr: got %h want 200000", err_addr2); else n_pass++;
        drive_xfer(22'h3abcde, 2'b11, 1'b1);
        err_clr = 1'b1;
        next_cycle();
        drive_idle(); HREADYS = 1'b0;
        #1;
        n_checks++; if (err_count2 !== 2'd1) $display("FAIL clrev_count: got %0d want 1", err_count2); else n_pass++;
        n_checks++; if (err_addr2 !== 22'h3abcde) $display("FAIL clrev_addr: got %h want 3abcde", err_addr2); else n_pass++;
        n_checks++; if (err_valid2 !== 1'b1) $display("FAIL clrev_valid: got %b want 1", err_valid2); else n_pass++;
        err_clr = 1'b1;
        next_cycle();
        drive_idle();
        #1;
        n_checks++; if (err_valid !== 1'b0) $display("FAIL clr_valid: got %b want 0", err_valid); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL clr_count: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (err_addr !== 22'h3abcde) $display("FAIL clr_addr_kept: got %h want 3abcde", err_addr); else n_pass++;
    endtask

    task automatic test_idle_lock;
        do_reset();
        drive_xfer(22'h140010, 2'b10, 1'b1);
        next_cycle();
        drive_xfer(22'h000000, 2'b00, 1'b1);
        #1;
        n_checks++; if (sel_vec !== 2'b01) $display("FAIL lock_sel_a: got %b want 01", sel_vec); else n_pass++;
        next_cycle();
        #1;
        n_checks++; if (sel_vec !== 2'b01) $display("FAIL lock_sel_b: got %b want 01", sel_vec); else n_pass++;
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b100) $display("FAIL lock_resp: got %b want 100", {HREADYOUTS, HRESPS}); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL lock_err_count: got %0d want 0", err_count); else n_pass++;
        drive_idle();
    endtask

    task automatic test_reset_mid_error;
        do_reset();
        drive_xfer(22'h200000, 2'b10, 1'b1);
        next_cycle();
        drive_idle(); HREADYS = 1'b0;
        #1;
        n_checks++; if (HREADYOUTS !== 1'b0) $display("FAIL rstmid_err1: got %b want 0", HREADYOUTS); else n_pass++;
        HRESET = 1'b1;
        next_cycle();
        HRESET = 1'b0; HREADYS = 1'b1;
        #1;
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b100) $display("FAIL rstmid_resp: got %b want 100", {HREADYOUTS, HRESPS}); else n_pass++;
        n_checks++; if (err_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", err_valid); else n_pass++;
        next_cycle();
        n_checks++; if ({HREADYOUTS, HRESPS} !== 3'b100) $display("FAIL rstmid_after: got %b want 100", {HREADYOUTS, HRESPS}); else n_pass++;
    endtask

    // Reference model state: data-phase owner, default-slave error phase, capture.
    int          m_dp, m_ph, m_cnt8, m_cnt2;
    logic        m_valid;
    logic [21:0] m_addr;

    function automatic int model_port(input logic [21:0] a, input logic [1:0] t);
        if (a >= 22'h140000 && a <= 22'h14012c) return 0;
        if (a >= 22'h140130 && a <= 22'h14013f) return 1;
        if (m_dp != DEF && t == 2'b00) return m_dp;
        return DEF;
    endfunction

    task automatic test_random;
        logic [21:0] picks [8] = '{22'h140000, 22'h14012c, 22'h14012d, 22'h140130,
                                   22'h14013f, 22'h140140, 22'h200000, 22'h000000};
        int          ap;
        logic        ev, e_ready;
        logic [1:0]  e_sel, e_resp;
        logic        e_act;
        logic [31:0] e_data;
        do_reset();
        m_dp = DEF; m_ph = 0; m_cnt8 = 0; m_cnt2 = 0; m_valid = 1'b0; m_addr = '0;
        for (int n = 0; n < 400; n++) begin
            sel_dec = ($urandom % 4) != 0;
            trans_dec = 2'($urandom);
            HREADYS = ($urandom % 4) != 0;
            err_clr = ($urandom % 12) == 0;
            HRESET = ($urandom % 64) == 0;
            decode_addr_dec = ($urandom % 10 < 8) ? picks[$urandom % 8] : 22'($urandom);
            active_vec = 2'($urandom); readyout_vec = 2'($urandom); resp_vec = 4'($urandom);
            rdata_vec = {$urandom, $urandom};
            #1;
            ap = model_port(decode_addr_dec, trans_dec);
            e_sel = (sel_dec && ap != DEF) ? 2'(1 << ap) : 2'b00;
            e_act = (ap == DEF) ? 1'b1 : active_vec[ap];
            if (m_dp != DEF) begin
                e_ready = readyout_vec[m_dp]; e_resp = resp_vec[2*m_dp +: 2];
                e_data = rdata_vec[32*m_dp +: 32];
            end else begin
                e_ready = (m_ph != 1); e_resp = (m_ph == 0) ? 2'b00 : 2'b01; e_data = '0;
            end
            n_checks++; if (sel_vec !== e_sel) $display("FAIL rnd_sel@%0d: got %b want %b", n, sel_vec, e_sel); else n_pass++;
            n_checks++; if (active_dec !== e_act) $display("FAIL rnd_active@%0d: got %b want %b", n, active_dec, e_act); else n_pass++;
            n_checks++; if (HREADYOUTS !== e_ready) $display("FAIL rnd_ready@%0d: got %b want %b", n, HREADYOUTS, e_ready); else n_pass++;
            n_checks++; if (HRESPS !== e_resp) $display("FAIL rnd_resp@%0d: got %b want %b", n, HRESPS, e_resp); else n_pass++;
            n_checks++; if (HRDATAS !== e_data) $display("FAIL rnd_rdata@%0d: got %h want %h", n, HRDATAS, e_data); else n_pass++;
            n_checks++; if (err_valid !== m_valid) $display("FAIL rnd_err_valid@%0d: got %b want %b", n, err_valid, m_valid); else n_pass++;
            n_checks++; if (err_addr !== m_addr) $display("FAIL rnd_err_addr@%0d: got %h want %h", n, err_addr, m_addr); else n_pass++;
            n_checks++; if (err_count !== 8'(m_cnt8)) $display("FAIL rnd_err_count@%0d: got %0d want %0d", n, err_count, m_cnt8); else n_pass++;
            n_checks++; if (err_count2 !== 2'(m_cnt2)) $display("FAIL rnd_err_count_w2@%0d: got %0d want %0d", n, err_count2, m_cnt2); else n_pass++;
            n_checks++; if ({sel_vec2, active_dec2, HREADYOUTS2, HRESPS2} !== {e_sel, e_act, e_ready, e_resp})
                $display("FAIL rnd_w2_bus@%0d: got %b want %b", n, {sel_vec2, active_dec2, HREADYOUTS2, HRESPS2}, {e_sel, e_act, e_ready, e_resp}); else n_pass++;
            n_checks++; if ({HRDATAS2, err_valid2, err_addr2} !== {e_data, m_valid, m_addr})
                $display("FAIL rnd_w2_cap@%0d: got %h want %h", n, {HRDATAS2, err_valid2, err_addr2}, {e_data, m_valid, m_addr}); else n_pass++;
            if (HRESET) begin
                m_dp = DEF; m_ph = 0; m_cnt8 = 0; m_cnt2 = 0; m_valid = 1'b0; m_addr = '0;
            end else begin
                ev = sel_dec && HREADYS && trans_dec[1] && ap == DEF;
                if (m_ph == 1) m_ph = 2;
                else m_ph = (sel_dec && ap == DEF && HREADYS && trans_dec[1]) ? 1 : 0;
                if (HREADYS) m_dp = ap;
                if (ev) begin
                    if (!m_valid || err_clr) m_addr = decode_addr_dec;
                    m_valid = 1'b1;
                    m_cnt8 = err_clr ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
                    m_cnt2 = err_clr ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
                end else if (err_clr) begin
                    m_valid = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
                end
            end
            next_cycle();
        end
        HRESET = 1'b0;
        drive_idle();
    endtask

    initial begin
        HRESET = 1'b1;
        test_reset();
        test_mapped();
        test_boundaries();
        test_unmapped();
        test_back_to_back();
        test_saturate();
        test_idle_lock();
        test_reset_mid_error();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
